// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU opcode encodings and operand selects.
package rv_pkg;
    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // alu_op = {b3, funct3}; b3 turns ADD into SUB and SRL into SRA
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    typedef enum logic [1:0] {SRC1_ZERO, SRC1_RS1, SRC1_PC} src1_sel_e;
    typedef enum logic [1:0] {SRC2_ZERO, SRC2_RS2, SRC2_IMM, SRC2_FOUR} src2_sel_e;
endpackage

// File: rtl/alu_ctrl.sv
// Combinational decode of opcode/funct3/funct7b5 into ALU opcode, operand
// selects and control bits. Unknown opcodes decode to all-zero control.
module alu_ctrl
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_op,
    output logic [1:0] src1_sel,
    output logic [1:0] src2_sel,
    output logic       uses_rs2,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       branch,
    output logic       jump
);
    always_comb begin
        alu_op    = ALU_ADD;
        src1_sel  = SRC1_ZERO;
        src2_sel  = SRC2_ZERO;
        uses_rs2  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        case (opcode)
            OPC_OP: begin
                src1_sel  = SRC1_RS1;
                src2_sel  = SRC2_RS2;
                alu_op    = {funct7b5, funct3};
                uses_rs2  = 1'b1;
                reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                src1_sel  = SRC1_RS1;
                src2_sel  = SRC2_IMM;
                // instr[30] is part of the immediate except for shift-right
                alu_op    = {(funct3 == 3'b101) & funct7b5, funct3};
                reg_write = 1'b1;
            end
            OPC_LOAD: begin
                src1_sel  = SRC1_RS1;
                src2_sel  = SRC2_IMM;
                mem_read  = 1'b1;
                reg_write = 1'b1;
            end
            OPC_STORE: begin
                src1_sel  = SRC1_RS1;
                src2_sel  = SRC2_IMM;
                mem_write = 1'b1;
                uses_rs2  = 1'b1;
            end
            OPC_BRANCH: begin
                src1_sel = SRC1_RS1;
                src2_sel = SRC2_RS2;
                alu_op   = ALU_SUB;
                uses_rs2 = 1'b1;
                branch   = 1'b1;
            end
            OPC_LUI: begin
                src2_sel  = SRC2_IMM;
                reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                src1_sel  = SRC1_PC;
                src2_sel  = SRC2_IMM;
                reg_write = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                src1_sel  = SRC1_PC;
                src2_sel  = SRC2_FOUR;
                jump      = 1'b1;
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand select, write-back forwarding, load-use hazard,
// stall and flush. Define ID_EX_PERF_EN to add stall/bubble performance counters.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_in1,
    output logic [XLEN-1:0]   alu_in2,
    output logic [3:0]        alu_op,
    output logic [XLEN-1:0]   store_data,
    output logic [REG_AW-1:0] rd,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch,
    output logic              jump,
    output logic [2:0]        br_funct3
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);
    import rv_pkg::*;

    logic [3:0] dec_alu_op;
    logic [1:0] dec_src1, dec_src2;
    logic       dec_uses_rs2, dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump;

    alu_ctrl u_alu_ctrl (
        .opcode    (in_opcode),
        .funct3    (in_funct3),
        .funct7b5  (in_funct7b5),
        .alu_op    (dec_alu_op),
        .src1_sel  (dec_src1),
        .src2_sel  (dec_src2),
        .uses_rs2  (dec_uses_rs2),
        .reg_write (dec_reg_write),
        .mem_read  (dec_mem_read),
        .mem_write (dec_mem_write),
        .branch    (dec_branch),
        .jump      (dec_jump)
    );

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d, store_data_q, store_data_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [REG_AW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [1:0]        src1_q, src1_d, src2_q, src2_d;
    logic              reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic              branch_q, branch_d, jump_q, jump_d;
    logic [2:0]        br_funct3_q, br_funct3_d;

    logic            hazard, capture, hit1, hit2;
    logic [XLEN-1:0] fwd1, fwd2;

    always_comb begin
        hazard   = valid_q & mem_read_q & (rd_q != '0) &
                   ((rd_q == in_rs1) | (dec_uses_rs2 & (rd_q == in_rs2)));
        in_ready = rst_n & (!valid_q | out_ready) & !hazard;
        capture  = in_valid & in_ready;
        fwd1     = (wb_we && wb_rd != '0 && wb_rd == in_rs1) ? wb_data : in_rs1_data;
        fwd2     = (wb_we && wb_rd != '0 && wb_rd == in_rs2) ? wb_data : in_rs2_data;
        hit1     = wb_we && wb_rd != '0 && wb_rd == rs1_q;
        hit2     = wb_we && wb_rd != '0 && wb_rd == rs2_q;

        valid_d      = valid_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        store_data_d = store_data_q;
        alu_op_d     = alu_op_q;
        rd_d         = rd_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        branch_d     = branch_q;
        jump_d       = jump_q;
        br_funct3_d  = br_funct3_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d      = 1'b1;
            rs1_d        = in_rs1;
            rs2_d        = in_rs2;
            src1_d       = dec_src1;
            src2_d       = dec_src2;
            alu_op_d     = dec_alu_op;
            store_data_d = fwd2;
            rd_d         = in_rd;
            reg_write_d  = dec_reg_write & (in_rd != '0);
            mem_read_d   = dec_mem_read;
            mem_write_d  = dec_mem_write;
            branch_d     = dec_branch;
            jump_d       = dec_jump;
            br_funct3_d  = dec_branch ? in_funct3 : 3'b000;
            case (dec_src1)
                SRC1_RS1: alu_in1_d = fwd1;
                SRC1_PC:  alu_in1_d = in_pc;
                default:  alu_in1_d = '0;
            endcase
            case (dec_src2)
                SRC2_RS2:  alu_in2_d = fwd2;
                SRC2_IMM:  alu_in2_d = in_imm;
                SRC2_FOUR: alu_in2_d = XLEN'(4);
                default:   alu_in2_d = '0;
            endcase
        end else if (valid_q) begin
            if (out_ready) valid_d = 1'b0;
            // a held instruction keeps picking up late write-backs of its sources
            if (hit1 && src1_q == SRC1_RS1) alu_in1_d = wb_data;
            if (hit2 && src2_q == SRC2_RS2) alu_in2_d = wb_data;
            if (hit2) store_data_d = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            store_data_q <= '0;
            alu_op_q     <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            br_funct3_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            store_data_q <= store_data_d;
            alu_op_q     <= alu_op_d;
            rd_q         <= rd_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            branch_q     <= branch_d;
            jump_q       <= jump_d;
            br_funct3_q  <= br_funct3_d;
        end
    end

    assign out_valid  = valid_q;
    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;
    assign alu_op     = alu_op_q;
    assign store_data = store_data_q;
    assign rd         = rd_q;
    assign reg_write  = reg_write_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign branch     = branch_q;
    assign jump       = jump_q;
    assign br_funct3  = br_funct3_q;

`ifdef ID_EX_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q + {31'd0, valid_q & !out_ready};
        bubble_cnt_d = bubble_cnt_q + {31'd0, hazard & out_ready};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif
endmodule
